// File: rtl/rc5_pkg.sv
// Shared definitions for the RC5 key-schedule blocks: key byte width and
// loader state encoding.
package rc5_pkg;

    localparam int unsigned KeyByteWidth = 8;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StLoad    = 3'd1,
        StFlush   = 3'd2,
        StStart   = 3'd3,
        StWaitExp = 3'd4,
        StDone    = 3'd5
    } key_state_e;

endpackage

// File: rtl/rc5_mod_counter.sv
// Modulo-(MAX+1) counter with synchronous clear, enable and terminal-count flag.
// Shared by the key loader and the key expander.
module rc5_mod_counter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned MAX   = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX);

    logic [WIDTH-1:0] count_q, count_d;

    // Clear takes priority so a restart in the same cycle as an increment wins.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = (count_q == MaxVal) ? '0 : count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign tc    = (count_q == MaxVal);

endmodule

// File: rtl/rc5_key_loader.sv
// RC5 key-schedule front end: streams the secret key into key_RAM port A,
// then kicks the key expander and reports completion.
module rc5_key_loader
    import rc5_pkg::*;
#(
    parameter  int unsigned B        = 16,
    localparam int unsigned B_LENGTH = $clog2(B)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    iLoad,
    input  logic                    iKeyValid,
    input  logic [KeyByteWidth-1:0] iKeyByte,
    output logic                    oKeyReady,
    output logic [B_LENGTH-1:0]     oKey_address,
    output logic [KeyByteWidth-1:0] oKey_data,
    output logic                    oKey_we,
    output logic                    oExpandStart,
    input  logic                    iExpanderDone,
    output logic                    oBusy,
    output logic                    oKeyLoaded,
    output logic                    oOverrun
);

    key_state_e state_q, state_d;

    logic                    transfer;
    logic                    count_clr;
    logic                    count_tc;
    logic [B_LENGTH-1:0]     count;

    logic                    we_q;
    logic [B_LENGTH-1:0]     addr_q;
    logic [KeyByteWidth-1:0] data_q;
    logic                    overrun_q;

    assign oKeyReady = (state_q == StLoad);
    assign transfer  = iKeyValid && oKeyReady;

    // Any accepted iLoad (re)enters LOAD, so the counter restarts on it.
    assign count_clr = iLoad && (state_q inside {StIdle, StLoad, StDone});

    rc5_mod_counter #(
        .WIDTH(B_LENGTH),
        .MAX  (B - 1)
    ) u_byte_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (count_clr),
        .en   (transfer),
        .count(count),
        .tc   (count_tc)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (iLoad) state_d = StLoad;
            end
            StLoad: begin
                if (iLoad) begin
                    state_d = StLoad;
                end else if (transfer && count_tc) begin
                    state_d = StFlush;
                end
            end
            StFlush:   state_d = StStart;
            StStart:   state_d = StWaitExp;
            StWaitExp: begin
                if (iExpanderDone) state_d = StDone;
            end
            StDone: begin
                if (iLoad) state_d = StLoad;
            end
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Address and data hold their last values when no write is issued.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            we_q      <= transfer;
            overrun_q <= iKeyValid && !oKeyReady;
            if (transfer) begin
                addr_q <= count;
                data_q <= iKeyByte;
            end
        end
    end

    assign oKey_we      = we_q;
    assign oKey_address = addr_q;
    assign oKey_data    = data_q;
    assign oOverrun     = overrun_q;
    assign oExpandStart = (state_q == StStart);
    assign oKeyLoaded   = (state_q == StDone);
    assign oBusy        = state_q inside {StLoad, StFlush, StStart, StWaitExp};

endmodule

// File: tb/tb_rc5_key_loader.sv
// Self-checking bench for rc5_key_loader: control-walk vector table plus
// scoreboarded key streams, abort, expander wait and async reset sequences.
module tb_rc5_key_loader;

    localparam int unsigned B = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       iLoad, iKeyValid, iExpanderDone;
    logic [7:0] iKeyByte;
    logic       oKeyReady, oKey_we, oExpandStart, oBusy, oKeyLoaded, oOverrun;
    logic [3:0] oKey_address;
    logic [7:0] oKey_data;

    rc5_key_loader #(
        .B(B)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .iLoad        (iLoad),
        .iKeyValid    (iKeyValid),
        .iKeyByte     (iKeyByte),
        .oKeyReady    (oKeyReady),
        .oKey_address (oKey_address),
        .oKey_data    (oKey_data),
        .oKey_we      (oKey_we),
        .oExpandStart (oExpandStart),
        .iExpanderDone(iExpanderDone),
        .oBusy        (oBusy),
        .oKeyLoaded   (oKeyLoaded),
        .oOverrun     (oOverrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct {
        string name;
        logic  load, valid, done;
        logic  ready, busy, loaded, start, overrun;
    } vec_t;

    wr_t  exp_q[$];
    vec_t vecs[5];
    int   n_checks = 0;
    int   n_fail = 0;
    int   start_cnt = 0;
    int   busy_bad;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Advance one clock, sample just after the edge and retire any RAM write.
    task automatic step();
        @(posedge clk);
        #1;
        if (oKey_we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(oKey_address), 32'(e.addr));
                check("wr_data", 32'(oKey_data), 32'(e.data));
            end
        end
        if (oExpandStart) start_cnt++;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic [3:0] addr);
        iKeyValid = 1'b1;
        iKeyByte  = b;
        check("ready_in_load", 32'(oKeyReady), 1);
        exp_q.push_back('{addr: addr, data: b});
        step();
        iKeyValid = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_outputs"}, {24'd0, oKeyReady, oKey_we, oExpandStart, oBusy,
              oKeyLoaded, oOverrun, 2'd0}, 0);
        check({name, "_addr_data"}, {20'd0, oKey_address, oKey_data}, 0);
    endtask

    task automatic wait_start(input string name);
        for (int k = 0; k < 8; k++) begin
            step();
            if (oExpandStart) break;
        end
        check(name, 32'(oExpandStart), 1);
    endtask

    // From START: one edge into WAIT_EXP, one more to see done.
    task automatic complete_expand();
        iExpanderDone = 1'b1;
        step();
        step();
        check("loaded_after_done", 32'(oKeyLoaded), 1);
        iExpanderDone = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{"idle_overrun", 0, 1, 0, 0, 0, 0, 0, 1};
        vecs[1] = '{"idle_quiet",   0, 0, 0, 0, 0, 0, 0, 0};
        vecs[2] = '{"idle_load",    1, 1, 0, 1, 1, 0, 0, 1};
        vecs[3] = '{"load_hold",    0, 0, 0, 1, 1, 0, 0, 0};
        vecs[4] = '{"load_restart", 1, 0, 1, 1, 1, 0, 0, 0};

        rst = 1'b0; iLoad = 1'b0; iKeyValid = 1'b0; iExpanderDone = 1'b0; iKeyByte = 8'h00;
        #1;
        check_all_zero("reset");
        step();
        #2 rst = 1'b1;
        step();
        check_all_zero("post_reset");

        // Control walk through IDLE into LOAD.
        foreach (vecs[i]) begin
            iLoad = vecs[i].load; iKeyValid = vecs[i].valid; iExpanderDone = vecs[i].done;
            step();
            check({vecs[i].name, "_flags"},
                  {27'd0, oKeyReady, oBusy, oKeyLoaded, oExpandStart, oOverrun},
                  {27'd0, vecs[i].ready, vecs[i].busy, vecs[i].loaded, vecs[i].start,
                   vecs[i].overrun});
            check({vecs[i].name, "_we"}, 32'(oKey_we), 0);
        end
        iLoad = 1'b0; iKeyValid = 1'b0; iExpanderDone = 1'b0;

        // Back-to-back stream with exact start latency.
        start_cnt = 0;
        for (int i = 0; i < 16; i++) send_byte(8'(i), 4'(i));
        check("flush_no_start", 32'(oExpandStart), 0);
        step();
        check("start_pulse", 32'(oExpandStart), 1);
        step();
        check("start_one_cycle", 32'(oExpandStart), 0);
        check("writes_drained_1", 32'(exp_q.size()), 0);

        // Overrun in WAIT_EXP, then a long expander wait with iLoad ignored.
        iKeyValid = 1'b1;
        step();
        iKeyValid = 1'b0;
        check("waitexp_overrun", {29'd0, oOverrun, oKeyReady, oBusy}, {29'd0, 3'b101});
        check("waitexp_overrun_no_we", 32'(oKey_we), 0);
        busy_bad = 0;
        for (int i = 0; i < 100; i++) begin
            iLoad = (i == 50);
            step();
            if (!oBusy || oKeyLoaded || oKeyReady) busy_bad++;
        end
        iLoad = 1'b0;
        check("busy_through_wait", busy_bad, 0);
        iExpanderDone = 1'b1;
        step();
        iExpanderDone = 1'b0;
        check("done_flags", {30'd0, oKeyLoaded, oBusy}, {30'd0, 2'b10});
        step();
        check("done_holds", 32'(oKeyLoaded), 1);
        check("single_start_1", start_cnt, 1);

        // Reload from DONE, bytes with random valid gaps.
        iLoad = 1'b1;
        step();
        iLoad = 1'b0;
        check("reload_drops_loaded", {30'd0, oKeyLoaded, oKeyReady}, {30'd0, 2'b01});
        for (int i = 0; i < 16; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                step();
                check("ready_in_gap", 32'(oKeyReady), 1);
            end
            send_byte(8'h30 + 8'(i), 4'(i));
        end
        wait_start("gap_start");
        complete_expand();
        check("writes_drained_2", 32'(exp_q.size()), 0);

        // Abort after 5 bytes, then a full key.
        start_cnt = 0;
        iLoad = 1'b1;
        step();
        iLoad = 1'b0;
        for (int i = 0; i < 5; i++) send_byte(8'h10 + 8'(i), 4'(i));
        iLoad = 1'b1;
        step();
        iLoad = 1'b0;
        for (int i = 0; i < 16; i++) send_byte(8'hA0 + 8'(i), 4'(i));
        wait_start("abort_start");
        complete_expand();
        check("abort_single_start", start_cnt, 1);

        // iLoad coinciding with the final byte: byte written, load restarts.
        start_cnt = 0;
        iLoad = 1'b1;
        step();
        iLoad = 1'b0;
        for (int i = 0; i < 15; i++) send_byte(8'h60 + 8'(i), 4'(i));
        iLoad = 1'b1;
        send_byte(8'h6F, 4'd15);
        iLoad = 1'b0;
        check("load_wins_state", 32'(oKeyReady), 1);
        step();
        check("load_wins_no_start", start_cnt, 0);
        for (int i = 0; i < 16; i++) send_byte(8'h80 + 8'(i), 4'(i));
        wait_start("load_wins_start");
        complete_expand();

        // Async reset between edges in the middle of a load.
        iLoad = 1'b1;
        step();
        iLoad = 1'b0;
        for (int i = 0; i < 3; i++) send_byte(8'hE0 + 8'(i), 4'(i));
        #2 rst = 1'b0;
        #1;
        check_all_zero("async_reset");
        #2 rst = 1'b1;
        exp_q.delete();
        step();
        check("after_reset_idle", {30'd0, oBusy, oKeyReady}, 0);
        iLoad = 1'b1;
        step();
        iLoad = 1'b0;
        for (int i = 0; i < 16; i++) send_byte(8'hC0 + 8'(i), 4'(i));
        wait_start("reset_restart_start");
        complete_expand();
        check("writes_drained_3", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
